div_iter_unit: RTL

Iterative radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU in the EX1 stage.
- Produces the 32-bit quotient and remainder that the EX1→EX2 pipeline register captures. That register selects between them using uop cond[0].
- Holds EX1 (ex1_readygo low) while busy.
- Holds its result until EX1 advances.
- Is cleared by pipeline flush.

---
 rtl/div_iter_unit_pkg.sv | 22 ++
 rtl/div_iter_unit_step.sv | 37 +++
 rtl/div_iter_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/div_iter_unit_pkg.sv
// div_iter_unit_pkg
// Shared definitions for the EX1 iterative divider:
//   - div_state_e : divider FSM state encoding (2 bits)
//   - COND_*      : uop cond bit assignments that the EX1->EX2 register uses
//                   to pick quotient or remainder and to tell signed/unsigned
//   - UOP_INS_DIV : uop bit that marks a DIV/MOD instruction
package div_iter_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // cond[0]: 1 = MOD (take remainder), 0 = DIV (take quotient)
  localparam int COND_SEL_REM  = 0;
  // cond[1]: 1 = unsigned variant (DIV.WU / MOD.WU)
  localparam int COND_UNSIGNED = 1;
  // Bit position of the divide instruction flag in the decoded uop
  localparam int UOP_INS_DIV   = 4;

endpackage

// File: rtl/div_iter_unit_step.sv
// div_iter_unit_step
// One radix-2 restoring-division iteration, purely combinational.
// Ports:
//   rem_i  in  WIDTH  partial remainder before the iteration
//   quo_i  in  WIDTH  dividend bits still to shift in / quotient bits so far
//   dvs_i  in  WIDTH  divisor magnitude
//   rem_o  out WIDTH  partial remainder after the iteration
//   quo_o  out WIDTH  shifted quotient with the new bit in bit 0
// Kept separate so two of these can later be chained for radix-4.
module div_iter_unit_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // {rem, quo} << 1: the shifted remainder needs WIDTH+1 bits because an
  // unsigned divisor near 2^WIDTH allows a remainder with its MSB set.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff_lo;
  logic           trial_ge;

  assign rem_sh = {rem_i, quo_i[WIDTH-1]};

  // Subtract on the low WIDTH bits only; the shifted-out MSB of rem_sh
  // stands in for the top bit of the WIDTH+1-wide trial. The trial is
  // non-negative if that MSB is set or the low subtract did not borrow.
  assign diff_lo  = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, dvs_i};
  assign trial_ge = rem_sh[WIDTH] | ~diff_lo[WIDTH];

  assign rem_o = trial_ge ? diff_lo[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_o = {quo_i[WIDTH-2:0], trial_ge};

endmodule

// File: rtl/div_iter_unit.sv
// div_iter_unit
// Iterative radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU in EX1.
// Works on magnitudes and fixes signs on the finalize edge. Quotient and
// remainder are both produced; the EX1->EX2 register picks one via cond[0].
// Ports:
//   clk        in   clock
//   aresetn    in   synchronous active-low reset
//   flush      in   pipeline flush, aborts any operation
//   start      in   issue request (accepted in IDLE, or in DONE with res_ack)
//   is_signed  in   1 = DIV.W/MOD.W, 0 = DIV.WU/MOD.WU
//   dividend   in   rj value
//   divisor    in   rk value
//   res_ack    in   EX1 advanced and consumed the result
//   busy       out  operation in progress (holds EX1)
//   done       out  quotient/remainder valid (div_ready)
//   quotient   out  result quotient, held while done
//   remainder  out  result remainder, held while done
// Latency: accept edge, 32 iteration edges, 1 finalize edge. Divide by zero
// skips the iterations and only takes the finalize edge.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             res_ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             fin_q, fin_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic             accept;

  div_iter_unit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Magnitudes; the most negative value maps to itself and is then
  // simply treated as an unsigned magnitude.
  assign dvd_abs = (is_signed & dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign dvs_abs = (is_signed & divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - divisor)  : divisor;

  // A new operation is taken from IDLE, or straight out of DONE when the
  // old result is consumed in the same cycle (back-to-back issue).
  assign accept = start & ((state_q == DIV_IDLE) | ((state_q == DIV_DONE) & res_ack));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    fin_d       = fin_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    unique case (state_q)
      DIV_CALC: begin
        if (fin_q) begin
          // Finalize edge: sign-correct and register the outputs.
          quotient_d  = neg_quo_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
          remainder_d = neg_rem_q ? ({WIDTH{1'b0}} - rem_q) : rem_q;
          fin_d       = 1'b0;
          state_d     = DIV_DONE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {CNT_W{1'b1}}) begin
            fin_d = 1'b1;
          end
        end
      end
      DIV_DONE: begin
        if (res_ack) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (accept) begin
      state_d = DIV_CALC;
      cnt_d   = '0;
      dvs_d   = dvs_abs;
      if (divisor == {WIDTH{1'b0}}) begin
        // Divide by zero: preload the architected result (all-ones
        // quotient, raw dividend as remainder) and go to finalize.
        quo_d     = {WIDTH{1'b1}};
        rem_d     = dividend;
        neg_quo_d = 1'b0;
        neg_rem_d = 1'b0;
        fin_d     = 1'b1;
      end else begin
        quo_d     = dvd_abs;
        rem_d     = '0;
        neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_rem_d = is_signed & dividend[WIDTH-1];
        fin_d     = 1'b0;
      end
    end

    // Flush wins over any start/ack this cycle; outputs are left as they
    // are since they are meaningless while done is low.
    if (flush) begin
      state_d = DIV_IDLE;
      fin_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      fin_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      fin_q       <= fin_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = (state_q == DIV_CALC);
  assign done      = (state_q == DIV_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
